// File: rtl/axis_frame_gate.sv
// axis_frame_gate: passes only whole video frames (tuser beat through the
// LINES_PER_FRAME-th tlast beat) from an AXI4-Stream input to a 2-entry
// skid-buffered output. Beats outside a frame are accepted and discarded.
// Optional statistics (frames_passed, beats_dropped, early_sof) are built
// only when the macro FRAME_GATE_STATS_EN is defined; otherwise those ports
// are tied to zero.
module axis_frame_gate #(
  parameter int DATA_W          = 64,
  parameter int LINES_PER_FRAME = 720
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              aclken,
  input  logic              ENABLE_GATE,
  input  logic              SW_RESET,
  input  logic [DATA_W-1:0] s_axis_video_tdata_in,
  input  logic              s_axis_video_tvalid_in,
  input  logic              s_axis_video_tuser_in,
  input  logic              s_axis_video_tlast_in,
  output logic              s_axis_video_tready_out,
  output logic [DATA_W-1:0] s_axis_video_tdata_out,
  output logic              s_axis_video_tvalid_out,
  output logic              s_axis_video_tuser_out,
  output logic              s_axis_video_tlast_out,
  input  logic              s_axis_video_tready_in,
  output logic [15:0]       frames_passed,
  output logic [15:0]       beats_dropped,
  output logic              early_sof
);

  localparam int          PW  = DATA_W + 2;
  localparam logic [11:0] LPF = 12'(LINES_PER_FRAME);

  typedef enum logic [1:0] {IDLE, SEEK, PASS} state_t;

  state_t         state;
  logic [11:0]    line_cnt;
  logic [1:0]     occ, occ_nxt;
  logic [PW-1:0]  buf0, buf1;   // buf0 is the head, driven straight to the outputs
  logic           tready_q;

  logic           rst;
  logic           accept, fwd, pop, frame_end;
  logic [11:0]    line_nxt;
  logic [PW-1:0]  beat_in;

  assign rst      = !aresetn || SW_RESET;
  assign beat_in  = {s_axis_video_tuser_in, s_axis_video_tlast_in, s_axis_video_tdata_in};
  assign accept   = aclken && s_axis_video_tvalid_in && tready_q;
  assign fwd      = accept && ((state == PASS) || (state == SEEK && s_axis_video_tuser_in));
  assign pop      = aclken && (occ != 2'd0) && s_axis_video_tready_in;
  // A tuser beat restarts the count; a beat carrying both tuser and tlast is line one.
  assign line_nxt  = (s_axis_video_tuser_in ? 12'd0 : line_cnt) + {11'd0, s_axis_video_tlast_in};
  assign frame_end = fwd && s_axis_video_tlast_in && (line_nxt == LPF);

  assign s_axis_video_tready_out = tready_q;
  assign s_axis_video_tvalid_out = (occ != 2'd0);
  assign s_axis_video_tdata_out  = buf0[DATA_W-1:0];
  assign s_axis_video_tlast_out  = buf0[DATA_W];
  assign s_axis_video_tuser_out  = buf0[DATA_W+1];

  // Buffer occupancy after this cycle; push+pop at occupancy 2 cannot happen.
  always_comb begin
    occ_nxt = occ;
    if (fwd && !pop)      occ_nxt = occ + 2'd1;
    else if (!fwd && pop) occ_nxt = occ - 2'd1;
  end

  // Gate FSM: only whole frames leave SEEK/PASS; enable drop never truncates.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state    <= IDLE;
      line_cnt <= 12'd0;
    end else if (aclken) begin
      case (state)
        IDLE: if (ENABLE_GATE) state <= SEEK;
        SEEK: begin
          if (fwd) begin
            line_cnt <= line_nxt;
            if (frame_end) state <= ENABLE_GATE ? SEEK : IDLE;
            else           state <= PASS;
          end else if (!ENABLE_GATE) begin
            state <= IDLE;
          end
        end
        PASS: begin
          if (fwd) begin
            line_cnt <= line_nxt;
            if (frame_end) state <= ENABLE_GATE ? SEEK : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer with registered ready (high while room remains).
  always_ff @(posedge aclk) begin
    if (rst) begin
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
      tready_q <= 1'b0;
    end else if (aclken) begin
      occ      <= occ_nxt;
      tready_q <= (occ_nxt != 2'd2);
      case ({fwd, pop})
        2'b10: if (occ == 2'd0) buf0 <= beat_in; else buf1 <= beat_in;
        2'b01: buf0 <= buf1;
        2'b11: buf0 <= beat_in;   // occupancy 1: head leaves, new beat takes its place
        default: ;
      endcase
    end
  end

`ifdef FRAME_GATE_STATS_EN
  logic sof_fwd;
  assign sof_fwd = fwd && s_axis_video_tuser_in;

  // Frame/drop statistics; frames wrap, drops saturate, early_sof is sticky.
  always_ff @(posedge aclk) begin
    if (rst) begin
      frames_passed <= 16'd0;
      beats_dropped <= 16'd0;
      early_sof     <= 1'b0;
    end else if (aclken) begin
      if (sof_fwd) frames_passed <= frames_passed + 16'd1;
      if (accept && !fwd && beats_dropped != 16'hFFFF) beats_dropped <= beats_dropped + 16'd1;
      if (sof_fwd && state == PASS) early_sof <= 1'b1;
    end
  end
`else
  assign frames_passed = 16'd0;
  assign beats_dropped = 16'd0;
  assign early_sof     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_gate.sv
// Directed bench for axis_frame_gate (LINES_PER_FRAME=2). Expected beats are
// queued when driven and compared in order as the output handshakes.
module tb_axis_frame_gate;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn, aclken, enable_gate, sw_reset;
  logic [DW-1:0] tdata_in;
  logic          tvalid_in, tuser_in, tlast_in, tready_out;
  logic [DW-1:0] tdata_out;
  logic          tvalid_out, tuser_out, tlast_out, tready_in;
  logic [15:0]   frames_passed, beats_dropped;
  logic          early_sof;

  axis_frame_gate #(.DATA_W(DW), .LINES_PER_FRAME(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .ENABLE_GATE(enable_gate), .SW_RESET(sw_reset),
    .s_axis_video_tdata_in(tdata_in), .s_axis_video_tvalid_in(tvalid_in),
    .s_axis_video_tuser_in(tuser_in), .s_axis_video_tlast_in(tlast_in),
    .s_axis_video_tready_out(tready_out),
    .s_axis_video_tdata_out(tdata_out), .s_axis_video_tvalid_out(tvalid_out),
    .s_axis_video_tuser_out(tuser_out), .s_axis_video_tlast_out(tlast_out),
    .s_axis_video_tready_in(tready_in),
    .frames_passed(frames_passed), .beats_dropped(beats_dropped), .early_sof(early_sof)
  );

  always #5 aclk = ~aclk;

  int              errors = 0;
  int              checks = 0;
  int              nfwd   = 0;
  logic [DW+1:0]   q[$];
  logic [DW+1:0]   prev_payload = '0;
  logic            prev_stall = 1'b0;
  logic            acc_seen   = 1'b0;
  logic [15:0]     exp_frames = 0, exp_drop = 0;
  logic            exp_early = 1'b0;

  function automatic logic [15:0] st(input logic [15:0] v);
`ifdef FRAME_GATE_STATS_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    logic          live, popd;
    logic [DW+1:0] pay, e;
    @(negedge aclk);
    live     = aresetn && !sw_reset;
    pay      = {tuser_out, tlast_out, tdata_out};
    acc_seen = tvalid_in && tready_out && aclken && live;
    popd     = tvalid_out && tready_in && aclken && live;
    if (prev_stall) begin
      chk("hold_valid", {63'd0, tvalid_out}, 64'd1);
      chk("hold_payload", {46'd0, pay}, {46'd0, prev_payload});
    end
    if (popd) begin
      if (q.size() == 0) chk("extra_beat", {46'd0, pay}, 64'hDEAD);
      else begin
        e = q.pop_front();
        chk("beat", {46'd0, pay}, {46'd0, e});
        nfwd++;
      end
    end
    prev_stall   = tvalid_out && !popd && live;
    prev_payload = pay;
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic u, input logic l, input logic fwd);
    int n;
    tvalid_in = 1'b1; tdata_in = d; tuser_in = u; tlast_in = l;
    if (fwd) begin
      q.push_back({u, l, d});
      if (u) exp_frames++;
    end else exp_drop++;
    n = 0;
    do begin tick(); n++; end while (!acc_seen && n < 100);
    if (!acc_seen) chk("accept_timeout", 64'd0, 64'd1);
    tvalid_in = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_frames"}, {48'd0, frames_passed}, {48'd0, st(exp_frames)});
    chk({tag, "_drops"},  {48'd0, beats_dropped}, {48'd0, st(exp_drop)});
    chk({tag, "_early"},  {63'd0, early_sof}, {63'd0, st({15'd0, exp_early}) != 0});
    chk({tag, "_q_empty"}, q.size(), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; aclken = 1'b1; enable_gate = 1'b1; sw_reset = 1'b0;
    tdata_in = '0; tvalid_in = 1'b0; tuser_in = 1'b0; tlast_in = 1'b0; tready_in = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_tready", {63'd0, tready_out}, 64'd0);
    chk("rst_tvalid", {63'd0, tvalid_out}, 64'd0);
    chk("rst_tdata",  {48'd0, tdata_out}, 64'd0);
    chk("rst_tuser",  {63'd0, tuser_out}, 64'd0);
    chk("rst_tlast",  {63'd0, tlast_out}, 64'd0);
    check_stats("rst");
    aresetn = 1'b1;
    tick();
    chk("tready_after_rst", {63'd0, tready_out}, 64'd1);

    // Three garbage beats then a 10-beat two-line frame
    nfwd = 0;
    for (int i = 0; i < 3; i++) send(16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0);
    send(16'h0100, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) send(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b1);
    send(16'h0104, 1'b0, 1'b1, 1'b1);
    for (int i = 5; i <= 8; i++) send(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b1);
    send(16'h0109, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    chk("frame1_count", nfwd, 64'd10);
    check_stats("frame1");
    send(16'hA0FF, 1'b0, 1'b0, 1'b0);   // back in SEEK: plain beat dropped
    repeat (3) tick();

    // Downstream stall during PASS
    nfwd = 0;
    tready_in = 1'b0;
    send(16'h0200, 1'b1, 1'b0, 1'b1);
    send(16'h0201, 1'b0, 1'b0, 1'b1);
    chk("stall_tready_low", {63'd0, tready_out}, 64'd0);
    repeat (3) tick();
    chk("stall_tready_still_low", {63'd0, tready_out}, 64'd0);
    tready_in = 1'b1;
    send(16'h0202, 1'b0, 1'b1, 1'b1);
    send(16'h0203, 1'b0, 1'b0, 1'b1);
    send(16'h0204, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    chk("stall_count", nfwd, 64'd5);
    check_stats("stall");

    // Enable dropped after first line: frame completes, then IDLE drops next frame
    nfwd = 0;
    send(16'h0300, 1'b1, 1'b0, 1'b1);
    send(16'h0301, 1'b0, 1'b1, 1'b1);
    enable_gate = 1'b0;
    send(16'h0302, 1'b0, 1'b0, 1'b1);
    send(16'h0303, 1'b0, 1'b1, 1'b1);
    send(16'h0310, 1'b1, 1'b0, 1'b0);
    send(16'h0311, 1'b0, 1'b1, 1'b0);
    send(16'h0312, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("disable_count", nfwd, 64'd4);
    check_stats("disable");
    enable_gate = 1'b1;
    tick();

    // Early start of frame after one of two lines
    nfwd = 0;
    send(16'h0400, 1'b1, 1'b0, 1'b1);
    send(16'h0401, 1'b0, 1'b1, 1'b1);
    send(16'h0402, 1'b1, 1'b0, 1'b1);
    exp_early = 1'b1;
    send(16'h0403, 1'b0, 1'b0, 1'b1);
    send(16'h0404, 1'b0, 1'b1, 1'b1);
    send(16'h0405, 1'b0, 1'b0, 1'b1);
    send(16'h0406, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("early_count", nfwd, 64'd7);
    check_stats("early");

    // tuser and tlast on one beat count as line one
    send(16'h0500, 1'b1, 1'b1, 1'b1);
    send(16'h0501, 1'b0, 1'b1, 1'b1);
    send(16'h0502, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_stats("sof_last");

    // Clock enable low freezes a buffered beat
    tready_in = 1'b0;
    send(16'h0600, 1'b1, 1'b0, 1'b1);
    aclken = 1'b0; tready_in = 1'b1;
    repeat (3) tick();
    chk("clken_tvalid", {63'd0, tvalid_out}, 64'd1);
    chk("clken_tdata", {48'd0, tdata_out}, 64'h0600);
    aclken = 1'b1;
    send(16'h0601, 1'b0, 1'b1, 1'b1);
    send(16'h0602, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    check_stats("clken");

    // Reset with two buffered beats
    tready_in = 1'b0;
    send(16'h0700, 1'b1, 1'b0, 1'b1);
    send(16'h0701, 1'b0, 1'b0, 1'b1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    q.delete();
    exp_frames = 0; exp_drop = 0; exp_early = 1'b0;
    chk("midrst_tvalid", {63'd0, tvalid_out}, 64'd0);
    chk("midrst_tready", {63'd0, tready_out}, 64'd0);
    check_stats("midrst");
    tready_in = 1'b1;
    nfwd = 0;
    send(16'h0710, 1'b0, 1'b0, 1'b0);
    send(16'h0711, 1'b0, 1'b1, 1'b0);
    send(16'h0720, 1'b1, 1'b0, 1'b1);
    send(16'h0721, 1'b0, 1'b1, 1'b1);
    send(16'h0722, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("postrst_count", nfwd, 64'd3);
    check_stats("postrst");

    // Software reset clears statistics
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    exp_frames = 0; exp_drop = 0;
    chk("swrst_tready", {63'd0, tready_out}, 64'd0);
    check_stats("swrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_frame_gate.md
AXIS_FRAME_GATE -- requirements
Module: axis_frame_gate

Interface
REQ-001 Parameter DATA_W, default 64, pixel-stream beat width in bits.
REQ-002 Parameter LINES_PER_FRAME, default 720, tlast beats per complete frame (range 1..4095).
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 aresetn  in  1  synchronous, active-low reset.
REQ-005 aclken  in  1  clock enable; when low, all state, counters and outputs hold.
REQ-006 ENABLE_GATE  in  1  software enable for forwarding frames.
REQ-007 SW_RESET  in  1  synchronous active-high software reset, same effect as aresetn low.
REQ-008 s_axis_video_tdata_in / tvalid_in / tuser_in / tlast_in  in  DATA_W/1/1/1  upstream AXI4-Stream video beat (tuser = start of frame, tlast = end of line).
REQ-009 s_axis_video_tready_out  out  1  upstream ready.
REQ-010 s_axis_video_tdata_out / tvalid_out / tuser_out / tlast_out  out  DATA_W/1/1/1  downstream beat to the keystone stage.
REQ-011 s_axis_video_tready_in  in  1  downstream ready.
REQ-012 frames_passed  out  16  count of frames started downstream, wraps at 0xFFFF->0.
REQ-013 beats_dropped  out  16  count of discarded input beats, saturates at 0xFFFF.
REQ-014 early_sof  out  1  sticky: tuser seen before LINES_PER_FRAME tlasts completed.

Function
REQ-015 The block SHALL forward only whole frames, from a tuser beat through the LINES_PER_FRAME-th tlast beat.
REQ-016 FSM states SHALL be IDLE, SEEK, PASS.
REQ-017 IDLE: input beats accepted (tready_out=1 if buffer not full) and discarded; ENABLE_GATE=1 -> SEEK.
REQ-018 SEEK: beats with tuser=0 accepted and discarded; accepted beat with tuser=1 is forwarded, line counter cleared, -> PASS; ENABLE_GATE=0 -> IDLE.
REQ-019 PASS: every accepted beat forwarded; line counter increments on each accepted tlast beat.
REQ-020 PASS: accepted tlast that brings the line counter to LINES_PER_FRAME -> SEEK if ENABLE_GATE=1, else IDLE.
REQ-021 ENABLE_GATE deasserted mid-frame SHALL NOT truncate the frame; transition occurs only per REQ-020.
REQ-022 PASS: accepted beat with tuser=1 before frame end SHALL be forwarded, line counter cleared, early_sof set, frames_passed incremented; state stays PASS.
REQ-023 Beat with tuser=1 and tlast=1 together SHALL count as both frame start and one line.
REQ-024 Output path SHALL be a 2-entry skid buffer; tready_out is a register, high iff buffer occupancy after the current cycle is < 2.
REQ-025 Latency input-accept to tvalid_out SHALL be 1 cycle when buffer empty; data, tuser, tlast travel together unmodified.
REQ-026 tvalid_out, once high, SHALL stay high with stable payload until tready_in=1 (AXI4-Stream rules).
REQ-027 Simultaneous push and pop with occupancy 2 SHALL NOT occur (tready_out low); with occupancy 1, occupancy stays 1.
REQ-028 frames_passed SHALL increment on each forwarded tuser beat; beats_dropped on each discarded beat.

Reset
REQ-029 On aresetn=0 or SW_RESET=1 at a rising edge (regardless of aclken): state IDLE, buffer empty, tvalid_out=0, tready_out=0, tuser_out=0, tlast_out=0, tdata_out=0, counters 0, early_sof=0.
REQ-030 tready_out SHALL rise the first enabled cycle after reset release.
REQ-031 Reset mid-frame SHALL discard buffered beats; the next frame resumes only via SEEK.

Configuration
REQ-032 Macro FRAME_GATE_STATS_EN: defined -> frames_passed, beats_dropped, early_sof implemented per REQ-012..014, REQ-022, REQ-028.
REQ-033 FRAME_GATE_STATS_EN undefined -> those ports SHALL exist and be constant 0, no counter logic; gating behaviour unchanged.

Verification
REQ-034 LINES_PER_FRAME=2, enable high, 3 garbage beats then frame (tuser beat, 3 beats, tlast, 4 beats, tlast) -> exactly 10 beats forwarded, beats_dropped=3, frames_passed=1, state SEEK.
REQ-035 Drop ENABLE_GATE after first tlast of a 2-line frame -> second line still forwarded, then IDLE; next tuser frame dropped.
REQ-036 tready_in held 0 for 5 cycles during PASS -> tready_out low after 2 accepted beats, no beat lost or duplicated, order preserved.
REQ-037 tuser after 1 of 2 lines -> early_sof=1, frames_passed=2, new frame forwarded in full.
REQ-038 aresetn low for 1 cycle with 2 buffered beats -> tvalid_out=0 next cycle, counters 0, following frame requires fresh tuser.
REQ-039 Build without FRAME_GATE_STATS_EN, rerun REQ-034 -> identical stream, all stats outputs 0.
